// File: rtl/i2c_master_pkg.sv
// -----------------------------------------------------------------------------
// i2c_master_pkg
// Shared constants for the byte-level I2C master: command codes, controller
// state encoding, quarter-phase indices and data/bit-counter widths.
// Ports: none (package).
// -----------------------------------------------------------------------------
package i2c_master_pkg;

   localparam int DATA_W = 8;   // bits per I2C byte
   localparam int BIT_W  = 3;   // bit index within a byte

   typedef enum logic [1:0] {
      CMD_START = 2'b00,
      CMD_WRITE = 2'b01,
      CMD_READ  = 2'b10,
      CMD_STOP  = 2'b11
   } cmd_t;

   typedef enum logic [2:0] {
      ST_IDLE,      // bus free, lines released
      ST_HOLD,      // bus owned, scl low, sda unchanged
      ST_START,     // START or repeated START sequence
      ST_DATA,      // eight data bits, MSB first
      ST_ACK,       // ninth (acknowledge) bit
      ST_STOP,      // STOP sequence plus bus free time
      ST_ILLEGAL    // one cycle to report a rejected command
   } state_t;

   typedef enum logic [1:0] {
      Q0 = 2'd0,
      Q1 = 2'd1,
      Q2 = 2'd2,
      Q3 = 2'd3
   } phase_t;

   // Only START may be issued while the bus is free.
   function automatic logic legal_cmd(input cmd_t c, input logic owned);
      return (c == CMD_START) || owned;
   endfunction

endpackage

// File: rtl/i2c_master_if.sv
// -----------------------------------------------------------------------------
// i2c_master_if
// Command/response handshake between local logic and the I2C master.
//   cmd_valid/cmd_ready : command handshake (accept when both high)
//   cmd                 : START / WRITE / READ / STOP
//   tx_data, ack_send   : WRITE byte and READ acknowledge bit
//   rx_data, ack_out    : READ byte and WRITE acknowledge result
//   done, err, busy     : completion pulse, illegal flag, bus ownership
// Modport master = the local logic issuing commands;
// modport slave  = the controller executing them.
// -----------------------------------------------------------------------------
interface i2c_master_if;
   import i2c_master_pkg::*;

   logic                cmd_valid;
   logic                cmd_ready;
   cmd_t                cmd;
   logic [DATA_W-1:0]   tx_data;
   logic                ack_send;
   logic [DATA_W-1:0]   rx_data;
   logic                ack_out;
   logic                done;
   logic                err;
   logic                busy;

   modport master (
      output cmd_valid, cmd, tx_data, ack_send,
      input  cmd_ready, rx_data, ack_out, done, err, busy
   );

   modport slave (
      input  cmd_valid, cmd, tx_data, ack_send,
      output cmd_ready, rx_data, ack_out, done, err, busy
   );

endinterface

// File: rtl/i2c_tick_gen.sv
// -----------------------------------------------------------------------------
// i2c_tick_gen
// Quarter-period divider: counts 0..QUARTER-1 and raises tick for one cycle
// on the last count.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : restart the quarter from count 0
//   freeze     : hold the count (clock stretching); no tick while frozen
//   tick       : single-cycle end-of-quarter pulse
// -----------------------------------------------------------------------------
module i2c_tick_gen #(
   parameter int QUARTER = 125
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic freeze,
   output logic tick
);

   localparam int CW = (QUARTER > 1) ? $clog2(QUARTER) : 1;
   localparam logic [CW-1:0] LAST = CW'(QUARTER - 1);

   logic [CW-1:0] count;

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (!freeze) begin
         count <= (count == LAST) ? '0 : count + CW'(1);
      end
   end

   assign tick = (count == LAST) && !freeze;

endmodule

// File: rtl/i2c_master.sv
// -----------------------------------------------------------------------------
// i2c_master
// Byte-level single-master I2C controller. Executes START/RESTART, WRITE byte,
// READ byte and STOP one command at a time, each bit split into four quarter
// phases q0..q3 of QUARTER clk cycles. scl/sda are open drain (0 or Z).
//   clk, reset : clock, asynchronous active-high reset (releases both lines)
//   sda, scl   : I2C bus lines
//   ctrl       : command handshake (i2c_master_if.slave)
// Parameter QUARTER : clk cycles per quarter SCL period (2..65535).
// Build option I2C_CLK_STRETCH_EN : when defined, a released scl that still
// reads low during q1 freezes the quarter counter (slave clock stretching).
// -----------------------------------------------------------------------------
module i2c_master
   import i2c_master_pkg::*;
#(
   parameter int QUARTER = 125
) (
   input  logic          clk,
   input  logic          reset,
   inout  wire           sda,
   inout  wire           scl,
   i2c_master_if.slave   ctrl
);

   state_t              state_q, state_d;
   phase_t              phase_q, phase_d;
   logic [BIT_W-1:0]    bit_q, bit_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic [DATA_W-1:0]   rx_q, rx_d;
   logic                rd_q, rd_d;        // current byte is a READ
   logic                restart_q, restart_d;
   logic                acks_q, acks_d;    // latched ack_send
   logic                ack_q, ack_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                busy_q, busy_d;
   logic                sda_oe_q, sda_oe_d; // 1 = pull sda low
   logic                scl_oe_q, scl_oe_d; // 1 = pull scl low

   logic                cmd_ready;
   logic                accept;
   logic                tick;
   logic                freeze;
   logic                sda_in;

   assign sda    = sda_oe_q ? 1'b0 : 1'bz;
   assign scl    = scl_oe_q ? 1'b0 : 1'bz;
   assign sda_in = sda;

   assign cmd_ready = (state_q == ST_IDLE) || (state_q == ST_HOLD);
   assign accept    = ctrl.cmd_valid && cmd_ready;

`ifdef I2C_CLK_STRETCH_EN
   // A slave holding the released scl low in q1 stops the quarter from running.
   assign freeze = (phase_q == Q1) && !scl_oe_q && (scl == 1'b0) &&
                   ((state_q == ST_START) || (state_q == ST_DATA) ||
                    (state_q == ST_ACK)   || (state_q == ST_STOP));
`else
   assign freeze = 1'b0;
`endif

   i2c_tick_gen #(
      .QUARTER (QUARTER)
   ) u_tick (
      .clk    (clk),
      .reset  (reset),
      .clear  (accept),
      .freeze (freeze),
      .tick   (tick)
   );

   // Line changes are applied at the tick that ends the current phase, so each
   // branch below sets up what the *next* phase drives.
   always_comb begin
      // NOTE: every next-state signal takes its hold value first, so no path
      // through the case statement can infer a latch.
      state_d   = state_q;
      phase_d   = phase_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      rx_d      = rx_q;
      rd_d      = rd_q;
      restart_d = restart_q;
      acks_d    = acks_q;
      ack_d     = ack_q;
      busy_d    = busy_q;
      sda_oe_d  = sda_oe_q;
      scl_oe_d  = scl_oe_q;
      done_d    = 1'b0;
      err_d     = 1'b0;

      case (state_q)
         ST_IDLE, ST_HOLD: begin
            if (accept) begin
               phase_d = Q0;
               bit_d   = '0;
               shift_d = ctrl.tx_data;
               acks_d  = ctrl.ack_send;
               if (!legal_cmd(ctrl.cmd, state_q == ST_HOLD)) begin
                  state_d = ST_ILLEGAL;
               end else begin
                  case (ctrl.cmd)
                     CMD_START: begin
                        // q0: release sda; scl stays as it is (Z idle, low held)
                        state_d   = ST_START;
                        restart_d = (state_q == ST_HOLD);
                        sda_oe_d  = 1'b0;
                     end
                     CMD_WRITE: begin
                        state_d  = ST_DATA;
                        rd_d     = 1'b0;
                        sda_oe_d = ~ctrl.tx_data[DATA_W-1];
                     end
                     CMD_READ: begin
                        state_d  = ST_DATA;
                        rd_d     = 1'b1;
                        sda_oe_d = 1'b0;
                     end
                     default: begin
                        state_d  = ST_STOP;
                        sda_oe_d = 1'b1;
                     end
                  endcase
               end
            end
         end

         ST_ILLEGAL: begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            err_d   = 1'b1;
         end

         ST_START: begin
            if (tick) begin
               phase_d = phase_t'(phase_q + 2'd1);
               case (phase_q)
                  Q0: if (restart_q) scl_oe_d = 1'b0;
                  Q1: sda_oe_d = 1'b1;   // sda falls while scl high
                  Q2: scl_oe_d = 1'b1;
                  default: begin
                     state_d = ST_HOLD;
                     busy_d  = 1'b1;
                     done_d  = 1'b1;
                  end
               endcase
            end
         end

         ST_DATA, ST_ACK: begin
            if (tick) begin
               phase_d = phase_t'(phase_q + 2'd1);
               case (phase_q)
                  Q0: scl_oe_d = 1'b0;
                  Q1: begin
                     // Sample after scl has been high for a full quarter.
                     if (state_q == ST_DATA && rd_q)
                        rx_d[BIT_W'(DATA_W-1) - bit_q] = sda_in;
                     if (state_q == ST_ACK && !rd_q)
                        ack_d = sda_in;
                  end
                  Q2: scl_oe_d = 1'b1;
                  default: begin
                     if (state_q == ST_ACK) begin
                        state_d = ST_HOLD;
                        done_d  = 1'b1;
                     end else if (bit_q == BIT_W'(DATA_W-1)) begin
                        state_d  = ST_ACK;
                        sda_oe_d = rd_q ? ~acks_q : 1'b0;
                     end else begin
                        bit_d    = bit_q + BIT_W'(1);
                        shift_d  = {shift_q[DATA_W-2:0], 1'b0};
                        sda_oe_d = ~rd_q & ~shift_q[DATA_W-2];
                     end
                  end
               endcase
            end
         end

         ST_STOP: begin
            if (tick) begin
               phase_d = phase_t'(phase_q + 2'd1);
               case (phase_q)
                  Q0: scl_oe_d = 1'b0;
                  Q1: sda_oe_d = 1'b0;   // sda rises while scl high
                  Q2: ;                  // q3 is bus free time
                  default: begin
                     state_d = ST_IDLE;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end
               endcase
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         phase_q   <= Q0;
         bit_q     <= '0;
         shift_q   <= '0;
         rx_q      <= '0;
         rd_q      <= 1'b0;
         restart_q <= 1'b0;
         acks_q    <= 1'b1;
         ack_q     <= 1'b1;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         sda_oe_q  <= 1'b0;
         scl_oe_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         rx_q      <= rx_d;
         rd_q      <= rd_d;
         restart_q <= restart_d;
         acks_q    <= acks_d;
         ack_q     <= ack_d;
         done_q    <= done_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
         sda_oe_q  <= sda_oe_d;
         scl_oe_q  <= scl_oe_d;
      end
   end

   assign ctrl.cmd_ready = cmd_ready;
   assign ctrl.rx_data   = rx_q;
   assign ctrl.ack_out   = ack_q;
   assign ctrl.done      = done_q;
   assign ctrl.err       = err_q;
   assign ctrl.busy      = busy_q;

endmodule

// File: tb/tb_i2c_master.sv
// -----------------------------------------------------------------------------
// tb_i2c_master
// Self-checking bench for i2c_master (QUARTER=4) with pull-ups on both lines
// and a behavioural slave that acknowledges writes or returns a byte on reads.
// Expected values come from a transaction-level model: latency per command,
// legality from bus ownership, bit sequence seen at each scl rise.
// -----------------------------------------------------------------------------
module tb_i2c_master;
   import i2c_master_pkg::*;

   localparam int Q = 4;
`ifdef I2C_CLK_STRETCH_EN
   localparam int STRETCH_EXTRA = 20;
`else
   localparam int STRETCH_EXTRA = 0;
`endif

   logic clk = 1'b0;
   logic reset;
   wire  sda_bus;
   wire  scl_bus;
   logic slv_sda_low = 1'b0;
   logic slv_scl_low = 1'b0;

   pullup (sda_bus);
   pullup (scl_bus);
   assign sda_bus = slv_sda_low ? 1'b0 : 1'bz;
   assign scl_bus = slv_scl_low ? 1'b0 : 1'bz;

   always #5 clk = ~clk;

   i2c_master_if m_if ();

   i2c_master #(.QUARTER(Q)) dut (
      .clk   (clk),
      .reset (reset),
      .sda   (sda_bus),
      .scl   (scl_bus),
      .ctrl  (m_if.slave)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // ---------------- bus monitor + slave model ----------------
   int         slv_mode = 0;      // 0 no responder, 1 ack writes, 2 send byte
   logic [7:0] slv_byte = 8'h00;
   logic       rise_q[$];
   int         n_start, n_stop, n_rise_lo, fall_cnt;
   bit         any_low, busy_low;
   logic       prev_scl = 1'b1;
   logic       prev_sda = 1'b1;

   always @(posedge clk) begin
      if (m_if.cmd_valid && m_if.cmd_ready) begin
         rise_q.delete();
         n_start = 0; n_stop = 0; n_rise_lo = 0; fall_cnt = 0;
         any_low = 0; busy_low = 0;
         slv_sda_low <= (slv_mode == 2) ? ~slv_byte[7] : 1'b0;
      end else begin
         if (!prev_scl && scl_bus) rise_q.push_back(sda_bus);
         if (prev_scl && !scl_bus) begin
            fall_cnt++;
            if (slv_mode == 1)
               slv_sda_low <= (fall_cnt == 8);
            else if (slv_mode == 2)
               slv_sda_low <= (fall_cnt < 8) ? ~slv_byte[3'(7 - fall_cnt)] : 1'b0;
            else
               slv_sda_low <= 1'b0;
         end
         if (scl_bus && prev_scl && prev_sda && !sda_bus) n_start++;
         if (scl_bus && prev_scl && !prev_sda && sda_bus) n_stop++;
         if (!scl_bus && !prev_sda && sda_bus) n_rise_lo++;
         if (!scl_bus || !sda_bus) any_low = 1;
         if (!m_if.busy) busy_low = 1;
      end
      prev_scl = scl_bus;
      prev_sda = sda_bus;
   end

   // ---------------- reference model ----------------
   bit         model_busy = 0;
   logic       model_ack  = 1'b1;
   logic [7:0] model_rx   = 8'h00;

   function automatic int exp_lat(input cmd_t c, input bit illegal);
      if (illegal) return 1;
      if (c == CMD_WRITE || c == CMD_READ) return 36 * Q;
      return 4 * Q;
   endfunction

   // ---------------- drivers ----------------
   task automatic accept_cmd(input cmd_t c, input logic [7:0] d, input logic a);
      int guard = 0;
      @(negedge clk);
      while (!m_if.cmd_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      m_if.cmd_valid = 1'b1;
      m_if.cmd       = c;
      m_if.tx_data   = d;
      m_if.ack_send  = a;
      @(negedge clk);
      m_if.cmd_valid = 1'b0;
   endtask

   task automatic run_cmd(input cmd_t c, input logic [7:0] d, input logic a,
                          input int hold_from, input int hold_to, input int poke_at,
                          output int lat, output logic e);
      accept_cmd(c, d, a);
      lat = 0;
      while (!m_if.done && lat < 2000) begin
         if (lat == hold_from) slv_scl_low = 1'b1;
         if (lat == hold_to)   slv_scl_low = 1'b0;
         if (lat == poke_at) begin
            m_if.cmd_valid = 1'b1;
            m_if.cmd       = CMD_STOP;
         end else begin
            m_if.cmd_valid = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      slv_scl_low    = 1'b0;
      m_if.cmd_valid = 1'b0;
      e = m_if.err;
   endtask

   task automatic do_op(input string tag, input cmd_t c, input logic [7:0] d,
                        input logic a, input int mode, input logic [7:0] sb);
      int         lat;
      logic       e;
      bit         illegal;
      logic [8:0] exp_bits, obs_bits;
      illegal  = (c != CMD_START) && !model_busy;
      slv_mode = mode;
      slv_byte = sb;
      run_cmd(c, d, a, -1, -1, -1, lat, e);
      check({tag, ".lat"}, lat, exp_lat(c, illegal));
      check({tag, ".err"}, e, illegal);
      if (illegal) begin
         check({tag, ".lines"}, any_low, 0);
      end else begin
         case (c)
            CMD_START: begin
               model_busy = 1;
               check({tag, ".start"}, n_start, 1);
            end
            CMD_STOP: begin
               model_busy = 0;
               check({tag, ".stop"}, n_stop, 1);
               check({tag, ".nostart"}, n_start, 0);
            end
            default: begin
               if (c == CMD_WRITE) begin
                  model_ack = (mode == 1) ? 1'b0 : 1'b1;
                  exp_bits  = {d, model_ack};
               end else begin
                  model_rx = sb;
                  exp_bits = {sb, a};
               end
               obs_bits = '1;
               for (int i = 0; i < 9 && i < rise_q.size(); i++) obs_bits[8 - i] = rise_q[i];
               check({tag, ".nrise"}, rise_q.size(), 9);
               check({tag, ".bits"}, obs_bits, exp_bits);
            end
         endcase
      end
      check({tag, ".busy"}, m_if.busy, model_busy);
      check({tag, ".ack_out"}, m_if.ack_out, model_ack);
      check({tag, ".rx_data"}, m_if.rx_data, model_rx);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int         lat;
      int         extra_done;
      logic       e;
      logic [7:0] d;

      reset          = 1'b1;
      m_if.cmd_valid = 1'b0;
      m_if.cmd       = CMD_START;
      m_if.tx_data   = 8'h00;
      m_if.ack_send  = 1'b1;
      repeat (3) @(negedge clk);
      check("rst.scl", scl_bus, 1'b1);
      check("rst.sda", sda_bus, 1'b1);
      check("rst.ready", m_if.cmd_ready, 1'b1);
      check("rst.done", m_if.done, 1'b0);
      check("rst.err", m_if.err, 1'b0);
      check("rst.busy", m_if.busy, 1'b0);
      check("rst.rx", m_if.rx_data, 8'h00);
      check("rst.ack", m_if.ack_out, 1'b1);
      reset = 1'b0;

      // Commands other than START are rejected while the bus is free.
      do_op("idle_stop",  CMD_STOP,  8'h00, 1'b1, 0, 8'h00);
      do_op("idle_write", CMD_WRITE, 8'h3C, 1'b1, 0, 8'h00);
      do_op("idle_read",  CMD_READ,  8'h00, 1'b1, 2, 8'hFF);

      do_op("start1", CMD_START, 8'h00, 1'b1, 0, 8'h00);
      do_op("wr_a4",  CMD_WRITE, 8'hA4, 1'b1, 1, 8'h00);
      do_op("wr_10",  CMD_WRITE, 8'h10, 1'b1, 0, 8'h00);
      do_op("stop1",  CMD_STOP,  8'h00, 1'b1, 0, 8'h00);

      do_op("start2", CMD_START, 8'h00, 1'b1, 0, 8'h00);
      do_op("wr_adr", CMD_WRITE, 8'hA5, 1'b1, 1, 8'h00);
      do_op("rd_5c",  CMD_READ,  8'h00, 1'b1, 2, 8'h5C);
      do_op("rd_ack", CMD_READ,  8'h00, 1'b0, 2, 8'($urandom));
      // Master left sda low after ACKing; RESTART must release it with scl low.
      do_op("restart", CMD_START, 8'h00, 1'b1, 0, 8'h00);
      check("restart.rise_lo", n_rise_lo, 1);
      check("restart.busy_kept", busy_low, 0);

      for (int i = 0; i < 8; i++) begin
         d = 8'($urandom);
         if ($urandom_range(0, 1) == 0)
            do_op($sformatf("rnd%0d_wr", i), CMD_WRITE, d, 1'b1, int'($urandom_range(0, 1)), 8'h00);
         else
            do_op($sformatf("rnd%0d_rd", i), CMD_READ, 8'h00, 1'($urandom_range(0, 1)), 2, d);
      end

      // A request while cmd_ready is low must be dropped, not queued.
      slv_mode = 1;
      run_cmd(CMD_WRITE, 8'h96, 1'b1, -1, -1, 10, lat, e);
      check("poke.lat", lat, 36 * Q);
      extra_done = 0;
      repeat (30) begin
         @(negedge clk);
         if (m_if.done) extra_done++;
      end
      check("poke.no_queue", extra_done, 0);
      check("poke.busy", m_if.busy, 1'b1);

      // Slave holds scl low through q1 of bit 3 (q1 begins 52 cycles in).
      slv_mode = 0;
      run_cmd(CMD_WRITE, 8'($urandom), 1'b1, 48, 72, -1, lat, e);
      check("stretch.lat", lat, 36 * Q + STRETCH_EXTRA);
      check("stretch.err", e, 1'b0);

      // Reset during bit 3 of a WRITE of 0x00 (master driving both lines low).
      slv_mode = 0;
      accept_cmd(CMD_WRITE, 8'h00, 1'b1);
      repeat (50) @(negedge clk);
      check("midrst.pre_sda", sda_bus, 1'b0);
      check("midrst.pre_scl", scl_bus, 1'b0);
      #1 reset = 1'b1;
      #1;
      check("midrst.sda", sda_bus, 1'b1);
      check("midrst.scl", scl_bus, 1'b1);
      check("midrst.ready", m_if.cmd_ready, 1'b1);
      check("midrst.busy", m_if.busy, 1'b0);
      @(negedge clk);
      reset      = 1'b0;
      model_busy = 0;
      model_ack  = 1'b1;
      model_rx   = 8'h00;

      do_op("start3", CMD_START, 8'h00, 1'b1, 0, 8'h00);
      do_op("stop3",  CMD_STOP,  8'h00, 1'b1, 0, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/i2c_master.md
Name: i2c_master

Overview:
- Byte-level, single-master I2C bus controller that drives `scl`/`sda` open-drain and issues START/RESTART, WRITE byte, READ byte and STOP on command from local logic.
- Counterpart initiator to the team's I2C slave; the two share the `I2C.vh` constant set and are co-simulated on one bus.
- Multi-master arbitration is out of scope.

Parameters:
- QUARTER, 125, clk cycles per quarter SCL period (125 → 100 kHz at 50 MHz); legal range 2..65535.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset (decided: one clock; reset asynchronous and active-high)
- sda  inout  1  I2C data; driven 0 or Z only
- scl  inout  1  I2C clock; driven 0 or Z only
- cmd_valid  input  1  command request
- cmd_ready  output  1  controller can accept a command
- cmd  input  2  00 START, 01 WRITE, 10 READ, 11 STOP
- tx_data  input  8  byte for WRITE (captured at accept)
- ack_send  input  1  READ: bit driven in ACK slot (0 = ACK, 1 = NACK; captured at accept)
- rx_data  output  8  byte received by READ
- ack_out  output  1  WRITE: sampled ACK bit (0 = slave acked)
- done  output  1  one-cycle pulse at command completion
- err  output  1  valid with done; command illegal in current bus state
- busy  output  1  bus owned (between START and STOP completion)

Behaviour:
- Reset values:
  - `sda` and `scl` both Z.
  - `cmd_ready`=1, `done`=0, `err`=0, `busy`=0, `rx_data`=0x00, `ack_out`=1.
  - State IDLE, quarter counter 0.
  - Reset mid-operation releases both lines immediately (asynchronously). A slave may be left mid-byte; the next START recovers it.
- Accept: a command is taken on the rising clk where `cmd_valid` && `cmd_ready`. `cmd_ready` drops the following cycle. `tx_data` and `ack_send` are latched.
- Tick: a counter 0..QUARTER-1 produces one tick per quarter. Each phase q0..q3 lasts one quarter. The counter is cleared at accept.
- States: IDLE (bus free), HOLD (bus owned, `scl` low, `sda` unchanged), START, DATA, ACK, STOP.
- START from IDLE:
  - q0: `sda` Z, `scl` Z.
  - q1: hold.
  - q2: `sda` 0.
  - q3: `scl` 0.
  - Then → HOLD, `busy`=1.
- START from HOLD (RESTART):
  - q0: `sda` Z (`scl` low).
  - q1: `scl` Z.
  - q2: `sda` 0.
  - q3: `scl` 0.
  - Then → HOLD.
- DATA: 8 bits, MSB first, 4 quarters per bit.
  - q0: `scl` 0; drive `sda` = bit for WRITE (Z for 1, 0 for 0), Z for READ.
  - q1: `scl` Z.
  - q2: READ samples `sda` into `rx_data[7-i]`.
  - q3: `scl` 0.
- ACK: same 4 phases as a data bit.
  - WRITE: `sda` Z; `ack_out` is sampled at q2.
  - READ: `sda` driven per latched `ack_send`.
  - End of q3 → HOLD.
- STOP from HOLD:
  - q0: `sda` 0.
  - q1: `scl` Z.
  - q2: `sda` Z.
  - q3: hold (bus free time).
  - Then → IDLE, `busy`=0.
- Latency from accept to `done`: START 4·QUARTER, WRITE/READ 36·QUARTER, STOP 4·QUARTER clk cycles. `done` and `cmd_ready` assert in the same cycle.
- Illegal commands: WRITE/READ/STOP while IDLE → no bus activity; `done`=1 and `err`=1 on the cycle after accept.
- START is always legal.
- `rx_data` and `ack_out` hold their values until the next READ or WRITE respectively.
- `cmd_valid` asserted while `cmd_ready`=0 is ignored (not queued).

Optional Feature:
- I2C_CLK_STRETCH_EN defined: in any q1 where `scl` is released, the tick counter is frozen while the `scl` input reads 0. The phase advances only after `scl` reads 1, then the full quarter runs. Latencies grow by the stretch time.
- Undefined: the `scl` input is never read; timing is purely counter-based.

Decomposition:
- `I2C.vh` holds:
  - command codes CMD_START/CMD_WRITE/CMD_READ/CMD_STOP;
  - master state encodings;
  - phase indices Q0..Q3;
  - shared width constants.
- Sub-module `i2c_tick_gen`: QUARTER divider with clear and freeze (stretch) inputs, single-cycle tick output.

Test Plan (QUARTER=4, pull-ups on bus, slave model or team I2C slave at address 0x52):
- START, WRITE 0xA4, slave acks → `sda` at each `scl` rise = 1,0,1,0,0,1,0,0; `ack_out`=0; `done` 144 clk after WRITE accept; `err`=0.
- START, WRITE 0x10 with no responder → `ack_out`=1; STOP → `sda` rises while `scl` high; `busy`=0 after `done`.
- READ, slave sends 0x5C, `ack_send`=1 → `rx_data`=0x5C; `sda` stays Z in the ACK slot; next READ with `ack_send`=0 → `sda`=0 in the ACK slot.
- STOP/WRITE/READ issued in IDLE → `done`=`err`=1 one cycle after accept; `scl`/`sda` never leave Z.
- START, WRITE, START (restart) → `sda` rises with `scl` low, then falls with `scl` high; `busy` stays 1 throughout.
- Reset asserted at bit 3 of a WRITE → both lines Z in the same cycle, `cmd_ready`=1. With I2C_CLK_STRETCH_EN, slave holding `scl` low 20 clk → that bit lengthens by 20 clk; without the macro, no change.
